// File: rtl/l1_dcache_pkg.sv
// Shared types and address-field helpers for the L1 data cache.
package cache_types;
  localparam int S_INDEX  = 4;
  localparam int S_OFFSET = 5;

  typedef logic [31:0]  rv32i_word;
  typedef logic [255:0] line_t;
  typedef logic [1:0]   cache_state_t;

  localparam cache_state_t CHECK     = 2'd0;
  localparam cache_state_t WRITEBACK = 2'd1;
  localparam cache_state_t ALLOCATE  = 2'd2;

  function automatic rv32i_word get_tag(input rv32i_word a, input int si);
    return a >> (S_OFFSET + si);
  endfunction

  function automatic int unsigned get_index(input rv32i_word a, input int si);
    return int'((a >> S_OFFSET) & ((32'd1 << si) - 32'd1));
  endfunction

  function automatic logic [2:0] get_word(input rv32i_word a);
    return a[4:2];
  endfunction
endpackage

// File: rtl/l1_dcache_ctrl.sv
// Miss-handling FSM and CPU/memory handshakes for l1_dcache.
// Optional L1_DCACHE_PERF_EN adds hit/miss/writeback counters.
module l1_dcache_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic mem_read,
  input  logic mem_write,
  input  logic hit,
  input  logic victim_dirty,
  input  logic pmem_resp,
  output logic mem_resp,
  output logic pmem_read,
  output logic pmem_write,
  output logic fill,
  output logic wr_hit
`ifdef L1_DCACHE_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic [31:0] wb_count
`endif
);
  import cache_types::*;

  cache_state_t state, state_nx;
  logic req;

  assign req    = mem_read | mem_write;
  assign wr_hit = mem_resp & mem_write;

  always_comb begin
    state_nx   = state;
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    fill       = 1'b0;
    case (state)
      CHECK: if (req) begin
        if (hit)               mem_resp = 1'b1;
        else if (victim_dirty) state_nx = WRITEBACK;
        else                   state_nx = ALLOCATE;
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        if (pmem_resp) state_nx = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          fill     = 1'b1;
          state_nx = CHECK;
        end
      end
      default: state_nx = CHECK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= CHECK;
    else     state <= state_nx;
  end

`ifdef L1_DCACHE_PERF_EN
  // The hit that completes a just-filled request belongs to its miss, not the hit count.
  logic after_fill;
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
      after_fill <= 1'b0;
    end else begin
      after_fill <= fill;
      if (mem_resp && !after_fill)              hit_count  <= hit_count + 32'd1;
      if (state == CHECK && req && !hit)        miss_count <= miss_count + 32'd1;
      if (state == WRITEBACK && pmem_resp)      wb_count   <= wb_count + 32'd1;
    end
  end
`endif
endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped write-back/write-allocate L1 D-cache: arrays, hit compare, byte merge.
// Optional L1_DCACHE_PERF_EN exposes hit_count/miss_count/wb_count.
module l1_dcache #(
  parameter int S_INDEX = cache_types::S_INDEX
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_wmask,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
`ifdef L1_DCACHE_PERF_EN
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count,
  output logic [31:0]  wb_count,
`endif
  input  logic         pmem_resp
);
  import cache_types::*;

  localparam int S_TAG = 32 - S_INDEX - S_OFFSET;
  localparam int SETS  = 2 ** S_INDEX;

  logic [S_TAG-1:0]   tag_arr [SETS];
  line_t              data_arr [SETS];
  logic [SETS-1:0]    valid, dirty;
  logic [S_INDEX-1:0] idx;
  logic [S_TAG-1:0]   req_tag;
  logic [2:0]         wsel;
  line_t              cur_line, wr_line;
  logic               hit, fill, wr_hit;

  assign idx      = S_INDEX'(get_index(mem_address, S_INDEX));
  assign req_tag  = S_TAG'(get_tag(mem_address, S_INDEX));
  assign wsel     = get_word(mem_address);
  assign cur_line = data_arr[idx];
  assign hit      = valid[idx] && (tag_arr[idx] == req_tag);

  l1_dcache_ctrl u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .hit          (hit),
    .victim_dirty (valid[idx] & dirty[idx]),
    .pmem_resp    (pmem_resp),
    .mem_resp     (mem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .fill         (fill),
    .wr_hit       (wr_hit)
`ifdef L1_DCACHE_PERF_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count),
    .wb_count     (wb_count)
`endif
  );

  always_comb begin
    wr_line = cur_line;
    for (int b = 0; b < 4; b++)
      if (mem_wmask[b]) wr_line[int'(wsel)*32 + b*8 +: 8] = mem_wdata[b*8 +: 8];
  end

  // A simultaneous read+write is treated as a write, so rdata stays quiet.
  assign mem_rdata = (mem_resp && !mem_write) ? cur_line[int'(wsel)*32 +: 32] : '0;

  always_comb begin
    pmem_address = '0;
    pmem_wdata   = '0;
    if (pmem_write) begin
      pmem_address = {tag_arr[idx], idx, {S_OFFSET{1'b0}}};
      pmem_wdata   = cur_line;
    end else if (pmem_read) begin
      pmem_address = {req_tag, idx, {S_OFFSET{1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill) begin
      data_arr[idx] <= pmem_rdata;
      tag_arr[idx]  <= req_tag;
      valid[idx]    <= 1'b1;
      dirty[idx]    <= 1'b0;
    end else if (wr_hit) begin
      data_arr[idx] <= wr_line;
      if (|mem_wmask) dirty[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (!rst) assert (!(mem_read && mem_write));
endmodule

// File: tb/tb_l1_dcache.sv
// Scoreboard bench for l1_dcache: flat golden memory, delayed line-memory responder.
module tb_l1_dcache;
  logic         clk = 1'b0;
  logic         rst, mem_read, mem_write, mem_resp;
  logic [3:0]   mem_wmask;
  logic [31:0]  mem_address, mem_wdata, mem_rdata, pmem_address;
  logic         pmem_read, pmem_write, pmem_resp;
  logic [255:0] pmem_wdata, pmem_rdata;
`ifdef L1_DCACHE_PERF_EN
  logic [31:0]  hit_count, miss_count, wb_count;
`endif

  l1_dcache dut (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_address(pmem_address),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata),
`ifdef L1_DCACHE_PERF_EN
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count),
`endif
    .pmem_resp(pmem_resp));

  always #5 clk = ~clk;

  typedef struct { bit wr; logic [31:0] a; logic [255:0] d; } pev_t;

  logic [255:0] mem  [logic [31:0]];
  logic [31:0]  gold [logic [31:0]];
  logic [31:0]  exp_q [$];
  pev_t         ev_q [$];
  int n_vec = 0, n_bad = 0, n_resp = 0, pm_delay = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] init_line(input logic [31:0] la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = la ^ (32'(i) * 32'h1111_1111) ^ 32'hA5A5_0000;
    return l;
  endfunction

  function automatic logic [255:0] get_line(input logic [31:0] la);
    if (mem.exists(la)) return mem[la];
    return init_line(la);
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    logic [255:0] l;
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (gold.exists(w)) return gold[w];
    l = get_line({a[31:5], 5'b0});
    return l[int'(a[4:2])*32 +: 32];
  endfunction

  function automatic logic [255:0] gold_line(input logic [31:0] la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = gold_rd(la + 32'(i*4));
    return l;
  endfunction

  task automatic gold_wr(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    logic [31:0] w;
    w = gold_rd(a);
    for (int b = 0; b < 4; b++) if (m[b]) w[b*8 +: 8] = d[b*8 +: 8];
    gold[{a[31:2], 2'b00}] = w;
  endtask

  // Line-memory responder: answers after pm_delay extra held cycles, logs every transaction.
  initial begin
    int cnt;
    pev_t e;
    cnt = 0; pmem_resp = 1'b0; pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (!rst && (pmem_read || pmem_write)) begin
        chk("pmem_excl", pmem_read & pmem_write, 1'b0);
        cnt++;
        if (cnt > pm_delay) begin
          e.wr = pmem_write; e.a = pmem_address; e.d = pmem_wdata;
          if (pmem_write) mem[pmem_address] = pmem_wdata;
          else pmem_rdata = get_line(pmem_address);
          ev_q.push_back(e);
          pmem_resp = 1'b1;
          cnt = 0;
        end
      end else cnt = 0;
    end
  end

  always @(negedge clk) begin
    #2;
    if (mem_resp) n_resp++;
  end

  task automatic cpu(input bit wr, input logic [31:0] a, input logic [3:0] m,
                     input logic [31:0] d, output int lat, output logic [31:0] rd);
    logic [31:0] e;
    bit done;
    @(negedge clk);
    mem_address = a; mem_read = !wr; mem_write = wr; mem_wmask = m; mem_wdata = d;
    if (wr) gold_wr(a, m, d);
    else exp_q.push_back(gold_rd(a));
    lat = 0; rd = '0; done = 0;
    while (!done) begin
      #2; lat++;
      if (mem_resp) begin
        rd = mem_rdata;
        if (!wr) begin
          e = exp_q.pop_front();
          chk($sformatf("rdata@%h", a), mem_rdata, e);
        end
        done = 1;
      end else if (lat >= 300) begin
        chk("resp_timeout", mem_resp, 1'b1);
        done = 1;
      end
      @(negedge clk);
    end
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic ev_pop(input bit wr, input logic [31:0] a, output logic [255:0] d);
    pev_t e;
    if (ev_q.size() > 0) e = ev_q.pop_front();
    else begin e.wr = !wr; e.a = '1; e.d = '0; end
    chk($sformatf("ev_kind@%h", a), e.wr, wr);
    chk($sformatf("ev_addr@%h", a), e.a, a);
    d = e.d;
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    gold.delete(); exp_q.delete();
  endtask

  initial begin
    int lat, n0;
    logic [31:0] rd, tmp;
    logic [255:0] l, d;
    logic [31:0] wa [3] = '{32'h1084, 32'h1088, 32'h108C};
    logic [3:0]  wm [3] = '{4'b1000, 4'b0101, 4'b1111};
    logic [31:0] wd [3] = '{32'hAABB_CCDD, 32'h1357_9BDF, 32'hCAFE_F00D};

    l = init_line(32'h40); l[95:64] = 32'hDEAD_BEEF; mem[32'h40] = l;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wmask = '0; mem_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rst_resp", mem_resp, 1'b0);
    chk("rst_pread", pmem_read, 1'b0);
    chk("rst_pwrite", pmem_write, 1'b0);
    chk("rst_paddr", pmem_address, 32'h0);
    chk("rst_pwdata", pmem_wdata, 256'h0);
    chk("rst_rdata", mem_rdata, 32'h0);

    // cold read miss, then 0-cycle hit in the same line
    cpu(0, 32'h40, 4'h0, 32'h0, lat, rd);
    ev_pop(0, 32'h40, d);
    chk("cold_lat", lat, 3);
    cpu(0, 32'h48, 4'h0, 32'h0, lat, rd);
    chk("hit_lat", lat, 1);
    chk("hit_beef", rd, 32'hDEAD_BEEF);

    // partial write hit keeps upper bytes
    cpu(1, 32'h44, 4'b0011, 32'h1234_5678, lat, rd);
    chk("wr_lat", lat, 1);
    cpu(0, 32'h44, 4'h0, 32'h0, lat, rd);
    tmp = l[63:32];
    chk("mask_lo", rd[15:0], 16'h5678);
    chk("mask_hi", rd[31:16], tmp[31:16]);
    chk("ev_none_hit", ev_q.size(), 0);

    // dirty conflict: writeback of modified line then fill
    cpu(0, 32'h1040, 4'h0, 32'h0, lat, rd);
    ev_pop(1, 32'h40, d);
    chk("wb_line", d, gold_line(32'h40));
    ev_pop(0, 32'h1040, d);
    chk("wb_lat", lat, 4);
    chk("ev_extra_wb", ev_q.size(), 0);

    // clean line with a zero-mask write stays clean; slow memory
    cpu(0, 32'h80, 4'h0, 32'h0, lat, rd);
    ev_pop(0, 32'h80, d);
    cpu(1, 32'h84, 4'b0000, 32'hFFFF_FFFF, lat, rd);
    chk("wr0_lat", lat, 1);
    pm_delay = 20;
    n0 = n_resp;
    cpu(0, 32'h1080, 4'h0, 32'h0, lat, rd);
    ev_pop(0, 32'h1080, d);
    chk("ev_extra_clean", ev_q.size(), 0);
    chk("slow_lat", lat, 23);
    chk("slow_resp_once", n_resp - n0, 1);
    pm_delay = 0;

    for (int i = 0; i < 3; i++) cpu(1, wa[i], wm[i], wd[i], lat, rd);
    for (int i = 0; i < 3; i++) cpu(0, wa[i], 4'h0, 32'h0, lat, rd);
    cpu(0, 32'h1080, 4'h0, 32'h0, lat, rd);
    chk("ev_none_wr", ev_q.size(), 0);

    // reset while allocating: pmem_read drops, index 2 line forgotten
    pm_delay = 30;
    @(negedge clk);
    mem_address = 32'h2040; mem_read = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("alloc_pread", pmem_read, 1'b1);
    chk("alloc_pwrite", pmem_write, 1'b0);
    chk("alloc_paddr", pmem_address, 32'h2040);
    rst = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    #2;
    chk("rst_mid_pread", pmem_read, 1'b0);
    chk("rst_mid_paddr", pmem_address, 32'h0);
    rst = 1'b0;
    gold.delete(); exp_q.delete();
    pm_delay = 0;
    cpu(0, 32'h1040, 4'h0, 32'h0, lat, rd);
    ev_pop(0, 32'h1040, d);
    chk("ev_extra_rst", ev_q.size(), 0);

    // CPU abandons a miss: fill still lands, no response
    pm_delay = 5;
    @(negedge clk);
    mem_address = 32'h3000; mem_read = 1'b1;
    repeat (2) @(negedge clk);
    mem_read = 1'b0;
    n0 = n_resp;
    repeat (12) @(negedge clk);
    chk("drop_noresp", n_resp - n0, 0);
    ev_pop(0, 32'h3000, d);
    pm_delay = 0;
    cpu(0, 32'h3000, 4'h0, 32'h0, lat, rd);
    chk("drop_fill_hit", lat, 1);

`ifdef L1_DCACHE_PERF_EN
    do_rst();
    ev_q.delete();
    #2;
    chk("perf_rst_hit", hit_count, 32'd0);
    chk("perf_rst_miss", miss_count, 32'd0);
    chk("perf_rst_wb", wb_count, 32'd0);
    cpu(0, 32'h40, 4'h0, 32'h0, lat, rd);
    cpu(1, 32'h40, 4'hF, 32'h0BAD_F00D, lat, rd);
    cpu(0, 32'h44, 4'h0, 32'h0, lat, rd);
    cpu(0, 32'h48, 4'h0, 32'h0, lat, rd);
    cpu(0, 32'h1040, 4'h0, 32'h0, lat, rd);
    #2;
    chk("perf_hit", hit_count, 32'd3);
    chk("perf_miss", miss_count, 32'd2);
    chk("perf_wb", wb_count, 32'd1);
    do_rst();
    #2;
    chk("perf_clr_hit", hit_count, 32'd0);
    chk("perf_clr_miss", miss_count, 32'd0);
    chk("perf_clr_wb", wb_count, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
